// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types for the pipeline sequencer
package pipeline_ctrl_pkg;
  typedef logic [4:0] regbits_t;
  typedef enum logic [1:0] {PC_RUN, PC_DRAIN, PC_HALTED} pctrl_state_t;
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
  } ctrl_t;
endpackage

// File: rtl/pipeline_ctrl_load_use.sv
// pipeline_ctrl_load_use: flags an ID instruction reading the destination of a load in EX
module pipeline_ctrl_load_use
  import pipeline_ctrl_pkg::*;
(
  input  logic     dren_ex,
  input  regbits_t wsel_ex,
  input  regbits_t rs_id,
  input  regbits_t rt_id,
  output logic     load_use
);
  assign load_use = dren_ex && wsel_ex != '0 && (wsel_ex == rs_id || wsel_ex == rt_id);
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: latch enable/flush sequencer with halt-drain FSM and stall/flush counters
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dren_mem,
  input  logic             dwen_mem,
  input  logic             dren_ex,
  input  regbits_t         wsel_ex,
  input  regbits_t         rs_id,
  input  regbits_t         rt_id,
  input  logic             mispredict,
  input  logic             halt_ex,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  pctrl_state_t st, nxt;
  ctrl_t        c;
  logic         load_use, busy, stall_inc, flush_inc;

  pipeline_ctrl_load_use u_lu (
    .dren_ex (dren_ex),
    .wsel_ex (wsel_ex),
    .rs_id   (rs_id),
    .rt_id   (rt_id),
    .load_use(load_use)
  );

  assign busy = (dren_mem || dwen_mem) && !dhit;

  // state register: RUN until a halt drains, then HALTED until reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= PC_RUN;
    else        st <= nxt;

  // priority mux for latch controls plus next-state; outputs forced low while in reset
  always_comb begin
    c         = '0;
    nxt       = st;
    flush_inc = 1'b0;
    if (st == PC_RUN) begin
      c = busy       ? ctrl_t'(7'b0000000) :
          mispredict ? ctrl_t'(7'b1111111) :
          load_use   ? ctrl_t'(7'b0011101) :
          !ihit      ? ctrl_t'(7'b0111110) :
                       ctrl_t'(7'b1111100);
      flush_inc = !busy && mispredict;
      nxt       = halt_ex && !busy ? PC_DRAIN : PC_RUN;
    end else if (st == PC_DRAIN) begin
      c   = ctrl_t'({1'b0, 1'b1, 1'b1, !busy, !busy, 1'b1, 1'b1});
      nxt = halt_wb ? PC_HALTED : PC_DRAIN;
    end
    if (!rst_n) c = '0;
  end

  assign stall_inc = st == PC_RUN && !c.pc_en;

  // saturating performance counters, advanced only while running
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end

  assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush} = c;
  assign halt = rst_n && st == PC_HALTED;
endmodule
